// File: rtl/systolic_operand_feeder.sv
// Operand feeder for the 4-lane systolic MAC array: reads one row tile from the tile buffer and skews it onto the lanes.
// Optional build macro FEEDER_ZERO_PAD_EN: invalid lanes drive zero data instead of holding their last value.
module systolic_operand_feeder #(
  parameter int N     = 8,
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int AW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  next_tile,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [LANES*DW-1:0]   rd_data,
  output logic [LANES*DW-1:0]   lane_data,
  output logic [LANES-1:0]      lane_valid,
  output logic [2:0]            row_tile,
  output logic                  next_tile_ready,
  output logic                  busy,
  output logic                  feed_done,
  output logic [1:0]            dbg_state
);

  localparam int NT  = N / LANES;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int DCW = $clog2(LANES + 2);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(N - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LANES);
  localparam logic [2:0]     TILE_LAST  = 3'(NT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [DCW-1:0] dcnt, dcnt_n;
  logic           pend, pend_n;
  logic           advance, adv_q;
  logic           rd_vld;
  logic [AW-1:0]  addr_n;
  logic [2:0]     tile_inc;

  assign dbg_state = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dcnt_n  = dcnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_READ;
          cnt_n   = '0;
        end
      end
      S_READ: begin
        if (cnt == CNT_LAST) begin
          state_n = S_DRAIN;
          dcnt_n  = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt == DRAIN_LAST) state_n = S_DONE;
        else                    dcnt_n  = dcnt + DCW'(1);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Pointer advances immediately when idle; otherwise one request is parked until the feed completes.
  always_comb begin
    advance = 1'b0;
    pend_n  = pend;
    case (state)
      S_IDLE: begin
        if (start) pend_n  = pend | next_tile;
        else       advance = next_tile;
      end
      S_DONE: begin
        advance = pend | next_tile;
        pend_n  = 1'b0;
      end
      default: pend_n = pend | next_tile;
    endcase
  end

  assign tile_inc = (row_tile == TILE_LAST) ? 3'd0 : row_tile + 3'd1;
  assign addr_n   = AW'(row_tile) * AW'(N) + AW'(cnt_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      dcnt            <= '0;
      pend            <= 1'b0;
      row_tile        <= 3'd0;
      adv_q           <= 1'b0;
      next_tile_ready <= 1'b0;
      busy            <= 1'b0;
      rd_en           <= 1'b0;
      rd_addr         <= '0;
      feed_done       <= 1'b0;
      rd_vld          <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      dcnt            <= dcnt_n;
      pend            <= pend_n;
      if (advance) row_tile <= tile_inc;
      adv_q           <= advance;
      next_tile_ready <= adv_q;
      busy            <= (state_n != S_IDLE);
      rd_en           <= (state_n == S_READ);
      feed_done       <= (state_n == S_DONE);
      if (state_n == S_READ) rd_addr <= addr_n;
      rd_vld          <= rd_en;
    end
  end

  // Lane k sees the captured word after k extra stages; stage 0 is the capture register.
  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      logic [k:0][DW-1:0] sd;
      logic [k:0]         sv;

      always_ff @(posedge clk) begin
        if (rst) begin
          sd <= '0;
          sv <= '0;
        end else begin
          sv[0] <= rd_vld;
`ifdef FEEDER_ZERO_PAD_EN
          sd[0] <= rd_vld ? rd_data[k*DW +: DW] : '0;
          for (int i = 1; i <= k; i++) sd[i] <= sv[i-1] ? sd[i-1] : '0;
`else
          if (rd_vld) sd[0] <= rd_data[k*DW +: DW];
          for (int i = 1; i <= k; i++) if (sv[i-1]) sd[i] <= sd[i-1];
`endif
          for (int i = 1; i <= k; i++) sv[i] <= sv[i-1];
        end
      end

      assign lane_data[k*DW +: DW] = sd[k];
      assign lane_valid[k]         = sv[k];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Bench for systolic_operand_feeder: timeline-based reference model checked every cycle, plus directed literal checks.
// Honours FEEDER_ZERO_PAD_EN for the expected value of invalid lanes.
module tb_systolic_operand_feeder;
  localparam int N = 8, LANES = 4, DW = 8, AW = 8;
  localparam int NT = N / LANES;
  localparam int LW = LANES * DW;
  localparam int FEED_LEN = N + LANES + 2;

  logic clk = 1'b0;
  logic rst, start, next_tile;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_data, lane_data;
  logic [LANES-1:0] lane_valid;
  logic [2:0] row_tile;
  logic next_tile_ready, busy, feed_done;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  systolic_operand_feeder #(.N(N), .LANES(LANES), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .next_tile(next_tile),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .lane_data(lane_data), .lane_valid(lane_valid), .row_tile(row_tile),
    .next_tile_ready(next_tile_ready), .busy(busy), .feed_done(feed_done),
    .dbg_state(dbg_state)
  );

  // Tile buffer: one cycle read latency, garbage when not reading.
  logic [LW-1:0] mem [2**AW];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : LW'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a feed is described only by the cycle its start was sampled in.
  int cyc = 0;
  int fs = -1000;
  int m_rt = 0, m_feed_rt = 0;
  bit m_pend = 0, m_live = 0;
  logic [1:0] ntr_sr = '0;
  logic [DW-1:0] last_v [LANES];

  always @(posedge clk) begin
    int r_prev;
    bit apply;
    r_prev = cyc - fs;
    apply  = 0;
    ntr_sr = ntr_sr >> 1;
    if (rst) begin
      fs = -1000; m_rt = 0; m_pend = 0; ntr_sr = '0; m_live = 1;
      for (int k = 0; k < LANES; k++) last_v[k] = '0;
    end else if (r_prev > FEED_LEN) begin
      if (start) begin
        fs = cyc; m_feed_rt = m_rt;
        if (next_tile) m_pend = 1;
      end else if (next_tile) apply = 1;
    end else if (r_prev == FEED_LEN) begin
      if (m_pend || next_tile) apply = 1;
      m_pend = 0;
    end else if (next_tile) m_pend = 1;
    if (apply) begin
      m_rt = (m_rt + 1) % NT;
      ntr_sr[1] = 1'b1;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    int r;
    bit v;
    logic [LW-1:0] w;
    logic [DW-1:0] ev;
    if (m_live) begin
      r = cyc - fs;
      chk("busy", busy, (r >= 1 && r <= FEED_LEN));
      chk("dbg_state_busy", (dbg_state != 2'd0), (r >= 1 && r <= FEED_LEN));
      chk("rd_en", rd_en, (r >= 1 && r <= N));
      chk("feed_done", feed_done, (r == FEED_LEN));
      if (r >= 1 && r <= N) chk("rd_addr", rd_addr, (m_feed_rt * N + r - 1) % (2**AW));
      for (int k = 0; k < LANES; k++) begin
        v = (r >= 3 + k) && (r <= N + 2 + k);
        chk("lane_valid", lane_valid[k], v);
        if (v) begin
          w = mem[(m_feed_rt * N + r - 3 - k) % (2**AW)];
          ev = w[k*DW +: DW];
          last_v[k] = ev;
        end else begin
`ifdef FEEDER_ZERO_PAD_EN
          ev = '0;
`else
          ev = last_v[k];
`endif
        end
        chk("lane_data", lane_data[k*DW +: DW], ev);
      end
      chk("row_tile", row_tile, m_rt);
      chk("next_tile_ready", next_tile_ready, ntr_sr[0]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] lane3_idle;
    rst = 1'b1; start = 1'b0; next_tile = 1'b0;
    for (int a = 0; a < 2**AW; a++)
      mem[a] = {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
    step(3);
    rst = 1'b0;
    chk("reset_row_tile", row_tile, 0);
    chk("reset_busy", busy, 0);
    chk("reset_lane_valid", lane_valid, 0);
    chk("reset_lane_data", lane_data, 0);

    // First feed from tile 0
    start = 1'b1; step(1); start = 1'b0;
    chk("t1_rd_addr_c1", rd_addr, 0);
    chk("t1_rd_en_c1", rd_en, 1);
    step(2);
    chk("t1_lane0_valid_c3", lane_valid[0], 1);
    chk("t1_lane0_c3", lane_data[7:0], 0);
    step(3);
    chk("t1_lane3_c6", lane_data[31:24], 3);
    step(7);
    chk("t1_lane3_c13", lane_data[31:24], 10);
    step(1);
    chk("t1_feed_done_c14", feed_done, 1);
    chk("t1_lane3_valid_c14", lane_valid[3], 0);
`ifdef FEEDER_ZERO_PAD_EN
    lane3_idle = 8'd0;
`else
    lane3_idle = 8'd10;
`endif
    chk("t1_lane3_c14", lane_data[31:24], lane3_idle);
    step(2);

    // Idle advance, then a feed from tile 1, then wrap
    next_tile = 1'b1; step(1); next_tile = 1'b0;
    chk("t2_row_tile", row_tile, 1);
    step(1);
    chk("t2_ntr", next_tile_ready, 1);
    start = 1'b1; step(1); start = 1'b0;
    chk("t2_rd_addr_c1", rd_addr, 8);
    step(7);
    chk("t2_rd_addr_c8", rd_addr, 15);
    step(8);
    next_tile = 1'b1; step(1); next_tile = 1'b0;
    chk("t2_wrap", row_tile, 0);
    step(2);

    // Two next_tile requests during a feed collapse into one advance at feed_done
    start = 1'b1; next_tile = 1'b1; step(1); start = 1'b0; next_tile = 1'b0;
    step(3);
    next_tile = 1'b1; step(1); next_tile = 1'b0;
    step(9);
    chk("t3_done", feed_done, 1);
    chk("t3_row_tile_c14", row_tile, 0);
    step(1);
    chk("t3_row_tile_c15", row_tile, 1);
    chk("t3_ntr_c15", next_tile_ready, 0);
    step(1);
    chk("t3_ntr_c16", next_tile_ready, 1);
    step(2);

    // start while busy is ignored; earliest back-to-back start is accepted
    start = 1'b1; step(1); start = 1'b0;
    step(1); start = 1'b1; step(1); start = 1'b0;
    step(11); start = 1'b1; step(1); start = 1'b0;
    chk("t4_busy_c15", busy, 0);
    chk("t4_rd_en_c15", rd_en, 0);
    start = 1'b1; step(1); start = 1'b0;
    chk("t4_new_busy", busy, 1);
    chk("t4_new_rd_addr", rd_addr, 8);
    step(16);

    // Reset mid-feed with a pending advance
    start = 1'b1; step(1); start = 1'b0;
    next_tile = 1'b1; step(1); next_tile = 1'b0;
    step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("t5_lane_valid", lane_valid, 0);
    chk("t5_lane_data", lane_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_row_tile", row_tile, 0);
    step(16);
    start = 1'b1; step(1); start = 1'b0;
    chk("t5_restart_rd_addr", rd_addr, 0);
    step(16);

    // Randomized traffic against the model
    for (int a = 0; a < 2**AW; a++) mem[a] = LW'($urandom);
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 5) == 0);
      next_tile = ($urandom_range(0, 6) == 0);
      step(1);
    end
    rst = 1'b0; start = 1'b0; next_tile = 1'b0;
    step(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_operand_feeder.md
# systolic_operand_feeder

Operand source for the 4-lane systolic MAC array. It answers the top controller's start pulse by reading one row tile of operand words from the tile buffer. Each word is broadcast onto the lanes with the diagonal skew the array expects. The block reports `busy` and a one-cycle `feed_done` back to the controller. It also owns the row-tile pointer that the controller advances with `next_tile`.

## Interface
Parameters:
- `N`, 8: matrix dimension; must be a multiple of `LANES`.
- `LANES`, 4: number of array lanes (rows per tile).
- `DW`, 8: element width in bits.
- `AW`, 8: buffer address width; must satisfy 2^AW ≥ N*N/LANES.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle request to feed the current row tile.
- `next_tile`, in, 1: single-cycle request to advance the row-tile pointer.
- `rd_en`, out, 1: buffer read strobe.
- `rd_addr`, out, AW: buffer word address.
- `rd_data`, in, LANES*DW: buffer word; valid exactly 1 cycle after `rd_en`. Lane k uses bits [k*DW +: DW].
- `lane_data`, out, LANES*DW: skewed operands; lane k at bits [k*DW +: DW].
- `lane_valid`, out, LANES: per-lane valid.
- `row_tile`, out, 3: current row-tile pointer.
- `next_tile_ready`, out, 1: one-cycle pulse when a pointer advance has been applied.
- `busy`, out, 1: feed in progress.
- `feed_done`, out, 1: one-cycle pulse when the feed completes.

## Operation
- Constant NT = N/LANES. Tile t occupies words t*N through t*N+N-1.
- States: S_IDLE, S_READ, S_DRAIN, S_DONE.
- S_IDLE:
  - `start` loads the read counter with 0 and moves to S_READ.
  - `start` has priority over `next_tile` in the same cycle; that `next_tile` becomes pending.
- S_READ:
  - `rd_en`=1 and `rd_addr` = `row_tile`*N + cnt, with cnt running 0..N-1.
  - After cnt = N-1, move to S_DRAIN.
- S_DRAIN: wait LANES+1 cycles, covering 1 cycle of read latency plus the LANES-1 skew stages and the output register. Then move to S_DONE.
- S_DONE: `feed_done`=1 for that single cycle, then move to S_IDLE.
- Skew: the captured word drives lane k through k extra register stages. `lane_valid[k]` travels with its data.
- `start` while `busy`=1 is ignored; it is not queued.
- `next_tile` pointer update:
  - In S_IDLE with no `start`: the pointer advances on the next edge, `row_tile` + 1, wrapping NT-1 → 0.
  - While `busy`: the request sets a single pending flag. Multiple requests collapse into one advance.
  - The pending advance is applied in the S_DONE cycle.
  - `next_tile_ready` pulses in the cycle after `row_tile` updates.
- All address arithmetic is unsigned, truncated to AW.

## Timing
- All outputs are registered.
- Reset values: `rd_en`=0, `rd_addr`=0, `lane_data`=0, `lane_valid`=0, `row_tile`=0, `next_tile_ready`=0, `busy`=0, `feed_done`=0. All state → S_IDLE, pending flag cleared.
- Feed timeline, with `start` sampled at edge 0:
  - `busy` is 1 in cycles 1 … N+LANES+2.
  - `rd_en` is 1 in cycles 1 … N.
  - `lane_valid[k]` is 1 in cycles 3+k … N+2+k.
  - `feed_done` is 1 in cycle N+LANES+2.
  - `busy` is 0 from cycle N+LANES+3.
- Earliest accepted back-to-back `start` is in cycle N+LANES+3.
- Reset during a feed:
  - Aborts it with no `feed_done`.
  - The skew pipe is cleared and `lane_valid` reads 0 on the next cycle.
  - Any pending advance is discarded.

## Configuration
- `FEEDER_ZERO_PAD_EN` defined: each lane's `lane_data` slice is forced to 0 whenever its `lane_valid` bit is 0, so the array accumulates zeros in skew bubbles.
- Not defined: a lane with `lane_valid`=0 holds its last value. `lane_data` may be stale, and consumers must gate on `lane_valid`.

## Test plan
- Reset, then `start` (N=8, LANES=4) with `rd_data` = {addr+3, addr+2, addr+1, addr}:
  - `rd_addr` reads 0..7 in cycles 1..8.
  - Lane 0 is valid in cycles 3..10 with values 0..7.
  - Lane 3 is valid in cycles 6..13 with values 3..10.
  - `feed_done` in cycle 14.
- `next_tile` in idle, then `start`:
  - `row_tile`=1, `next_tile_ready` pulses.
  - `rd_addr` runs 8..15.
  - A second `next_tile` wraps `row_tile` to 0.
- `next_tile` pulsed twice mid-feed, with `start` in the same cycle as one of them:
  - One advance only, applied at `feed_done`.
  - `row_tile` 0→1, then `next_tile_ready` 1 cycle later.
- `start` re-pulsed in cycles 2 and N+LANES+2: ignored; no extra `rd_en`. A `start` in cycle N+LANES+3 begins a new feed.
- `rst` asserted in cycle 5 of a feed:
  - All outputs are reset values the following cycle; no `feed_done`; `row_tile`=0.
  - A later `start` behaves exactly as after power-on.
- Build with and without `FEEDER_ZERO_PAD_EN`: lane 3 `lane_data` in cycle 14 reads 0 when defined and 10 when not.
